// File: rtl/rv32i_types.sv
// Shared RV32I types for the memory stage: control word, MEM FSM states,
// funct3 load/store width codes and the misalignment check.
package rv32i_types;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_read;
    logic       mem_write;
    logic       load_regfile;
    logic [4:0] rd;
  } rv32i_control_word;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_BUSY = 2'd1,
    MA_HOLD = 2'd2
  } ma_state_e;

  // Halfwords need bit 0 clear, words need both low bits clear; bytes never trap.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic m;
    m = 1'b0;
    case (f3)
      F3_H, F3_HU: m = lo[0];
      F3_W:        m = |lo;
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_align.sv
// Store lane steering: shifts store data into its byte lanes and builds the
// byte-enable mask. Loads always request the full word.
module store_align
  import rv32i_types::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  output logic [31:0] wdata,
  output logic [3:0]  mbe
);

  always_comb begin
    wdata = rs2 << {addr_lo, 3'b000};
    mbe   = 4'b1111;
    if (is_store) begin
      case (funct3)
        F3_B:    mbe = 4'b0001 << addr_lo;
        F3_H:    mbe = 4'b0011 << {addr_lo[1], 1'b0};
        default: mbe = 4'b1111;
      endcase
    end
  end

endmodule

// File: rtl/memory_access.sv
// MEM stage: issues data-memory requests, stalls until dmem_resp, and owns the
// MEM/WB register. `define MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module memory_access
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              ex_valid,
  input  rv32i_control_word ctrl,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       rs2_out,
  input  logic              br_en,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [31:0]       dmem_address,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_mbe,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              stall_out,
  output logic              wb_valid,
  output rv32i_control_word wb_ctrl,
  output logic [31:0]       wb_alu_out,
  output logic              wb_br_en,
  output logic [31:0]       wb_mem_data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              wb_misaligned
`endif
);

  ma_state_e         state, state_nx;
  logic              memop, misalign, issue, load_en;
  logic [31:0]       rbuf;
  logic              req_rd_q, req_wr_q;
  logic [31:0]       addr_q, wdata_q;
  logic [3:0]        mbe_q;
  logic [31:0]       sa_wdata;
  logic [3:0]        sa_mbe;
  rv32i_control_word ctrl_wb;

  assign memop = ex_valid & (ctrl.mem_read | ctrl.mem_write);
`ifdef MISALIGN_TRAP_EN
  assign misalign = memop & is_misaligned(ctrl.funct3, alu_out[1:0]);
`else
  assign misalign = 1'b0;
`endif
  assign issue   = memop & ~misalign;
  assign load_en = ~stall_in & ~stall_out;

  store_align u_align (
    .is_store (ctrl.mem_write),
    .funct3   (ctrl.funct3),
    .addr_lo  (alu_out[1:0]),
    .rs2      (rs2_out),
    .wdata    (sa_wdata),
    .mbe      (sa_mbe)
  );

  // IDLE drives the request straight from EX/MEM; BUSY replays the captured copy.
  always_comb begin
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = {alu_out[31:2], 2'b00};
    dmem_wdata   = sa_wdata;
    dmem_mbe     = sa_mbe;
    stall_out    = 1'b0;
    state_nx     = state;
    case (state)
      MA_IDLE: if (issue) begin
        dmem_read  = ctrl.mem_read;
        dmem_write = ctrl.mem_write;
        stall_out  = ~dmem_resp;
        if (!dmem_resp)    state_nx = MA_BUSY;
        else if (stall_in) state_nx = MA_HOLD;
      end
      MA_BUSY: begin
        dmem_read    = req_rd_q;
        dmem_write   = req_wr_q;
        dmem_address = addr_q;
        dmem_wdata   = wdata_q;
        dmem_mbe     = mbe_q;
        stall_out    = ~dmem_resp;
        if (dmem_resp) state_nx = stall_in ? MA_HOLD : MA_IDLE;
      end
      MA_HOLD: if (!stall_in) state_nx = MA_IDLE;
      default: state_nx = MA_IDLE;
    endcase
    // Reset must kill the strobes without waiting for a clock edge.
    if (!rst) begin
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      stall_out  = 1'b0;
    end
  end

  always_comb begin
    ctrl_wb              = ctrl;
    ctrl_wb.load_regfile = ctrl.load_regfile & ~misalign;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= MA_IDLE;
      rbuf     <= '0;
      req_rd_q <= 1'b0;
      req_wr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mbe_q    <= '0;
    end else begin
      state <= state_nx;
      if (state == MA_IDLE && issue) begin
        req_rd_q <= ctrl.mem_read;
        req_wr_q <= ctrl.mem_write;
        addr_q   <= {alu_out[31:2], 2'b00};
        wdata_q  <= sa_wdata;
        mbe_q    <= sa_mbe;
      end
      if (dmem_resp && ((state == MA_IDLE && issue) || state == MA_BUSY))
        rbuf <= dmem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid      <= 1'b0;
      wb_ctrl       <= '0;
      wb_alu_out    <= '0;
      wb_br_en      <= 1'b0;
      wb_mem_data   <= '0;
`ifdef MISALIGN_TRAP_EN
      wb_misaligned <= 1'b0;
`endif
    end else if (load_en) begin
      wb_valid   <= ex_valid;
      wb_ctrl    <= ctrl_wb;
      wb_alu_out <= alu_out;
      wb_br_en   <= br_en;
      if (issue && ctrl.mem_read)
        wb_mem_data <= (state == MA_HOLD) ? rbuf : dmem_rdata;
`ifdef MISALIGN_TRAP_EN
      wb_misaligned <= misalign;
`endif
    end
  end

endmodule
